conv_seq_ctrl: RTL and testbench

- Control FSM that sequences one parallel 1-D convolution datapath (conv_N_M_T_P family) through load, compute, drain and output phases.
- Owns the input-stream handshake and the output-stream valid.
- Generates X-memory write/read addresses, weight-ROM address, accumulator clear/enable and output-lane select.
- The datapath holds memories, MAC lanes and the data mux; this block holds no data.

---
 rtl/conv_seq_pkg.sv | 28 ++
 rtl/conv_seq_dly.sv | 35 +++
 rtl/conv_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and elaboration helpers for the convolution sequencer.
//   state_t      : sequencer phases (IDLE, LOAD, COMPUTE, DRAIN, OUTPUT)
//   clog2_min1   : address width that never collapses to zero bits
//   conv_nout    : number of valid convolution outputs, N-M+1
//   conv_groups  : number of P-wide output groups per vector
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int conv_nout(input int n, input int m);
    return n - m + 1;
  endfunction

  function automatic int conv_groups(input int n, input int m, input int p);
    return (p > 0) ? conv_nout(n, m) / p : 0;
  endfunction

endpackage

// File: rtl/conv_seq_dly.sv
// W-bit delay line of DEPTH register stages, asynchronously cleared.
// DEPTH = 0 degenerates to a wire.
//   clk, reset : clock and asynchronous active-high reset
//   d_i        : input word
//   q_o        : d_i delayed by DEPTH cycles
module conv_seq_dly #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk | reset;
    assign q_o = d_i;
  end else begin : g_sr
    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Control sequencer for a P-lane parallel 1-D convolution datapath.
// Loads N input words into X memory, then for each of G = (N-M+1)/P groups
// issues M tap reads, waits for the MAC pipeline to drain, captures the lane
// results and streams them out one lane at a time. Holds no data itself.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   s_valid_x/s_ready_x input word handshake (ready only in LOAD)
//   x_wr_en/x_wr_addr   X-memory write strobe and address
//   x_rd_addr           base X read address (lane i reads x_rd_addr+i)
//   w_rd_addr           weight-ROM address (tap index)
//   mac_clr/mac_en      lane accumulator load / accumulate, aligned to read data
//   res_ld              capture lane results into the output register
//   out_sel/m_valid_y   output lane select and output valid
//   m_ready_y           downstream ready
//
// Optional build macro CONV_SEQ_CTRL_PERF_EN adds saturating 32-bit
// counters perf_vec_cnt (completed vectors) and perf_stall_cnt (output
// cycles stalled by downstream).
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int N       = 64,
  parameter int M       = 33,
  parameter int P       = 4,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2,
  localparam int AW     = clog2_min1(N),
  localparam int WW     = clog2_min1(M),
  localparam int SW     = clog2_min1(P)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  output logic          x_wr_en,
  output logic [AW-1:0] x_wr_addr,
  output logic [AW-1:0] x_rd_addr,
  output logic [WW-1:0] w_rd_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          res_ld,
  output logic [SW-1:0] out_sel,
  output logic          m_valid_y,
  input  logic          m_ready_y
`ifdef CONV_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_vec_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int NOUT = conv_nout(N, M);
  localparam int G    = conv_groups(N, M, P);
  localparam int GW   = clog2_min1(G);
  // DRAIN covers the read latency, the final accumulate and the MAC latency.
  localparam int DLAT = RD_LAT + MAC_LAT;
  localparam int DW   = clog2_min1(DLAT + 1);

  localparam logic [AW-1:0] N1     = AW'(N - 1);
  localparam logic [WW-1:0] M1     = WW'(M - 1);
  localparam logic [SW-1:0] P1     = SW'(P - 1);
  localparam logic [GW-1:0] G1     = GW'(G - 1);
  localparam logic [AW-1:0] P_AW   = AW'(P);
  localparam logic [DW-1:0] DLAT_C = DW'(DLAT);

  if ((M > N) || (P < 1) || ((NOUT % P) != 0)) begin : g_cfg_err
    $error("conv_seq_ctrl: illegal N/M/P (need M<=N and (N-M+1)%%P==0)");
  end

  state_t        state_q;
  logic [AW-1:0] wcnt_q;
  logic [WW-1:0] k_q;
  logic [GW-1:0] g_q;
  logic [SW-1:0] lane_q;
  logic [DW-1:0] dcnt_q;
  logic [AW-1:0] xrd_q;
  logic [AW-1:0] gbase_q;
  logic          s_ready_q;
  logic          m_valid_q;
  logic          res_ld_q;

  logic          iss;
  logic          first;
  logic [1:0]    mac_ctl;

  assign iss   = (state_q == COMPUTE);
  assign first = (k_q == '0);

  // Tap-issue strobes travel alongside the memory read so that mac_en and
  // mac_clr line up with the data the datapath sees.
  conv_seq_dly #(
    .W     (2),
    .DEPTH (RD_LAT)
  ) u_mac_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   ({iss & first, iss}),
    .q_o   (mac_ctl)
  );

  assign mac_en    = mac_ctl[0];
  assign mac_clr   = mac_ctl[1];
  assign s_ready_x = s_ready_q;
  assign x_wr_en   = s_valid_x & s_ready_q;
  assign x_wr_addr = wcnt_q;
  assign x_rd_addr = xrd_q;
  assign w_rd_addr = k_q;
  assign out_sel   = lane_q;
  assign m_valid_y = m_valid_q;
  assign res_ld    = res_ld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      k_q       <= '0;
      g_q       <= '0;
      lane_q    <= '0;
      dcnt_q    <= '0;
      xrd_q     <= '0;
      gbase_q   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      res_ld_q  <= 1'b0;
    end else begin
      res_ld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q   <= LOAD;
          s_ready_q <= 1'b1;
        end

        LOAD: begin
          if (x_wr_en) begin
            if (wcnt_q == N1) begin
              // Last word accepted: compute starts on the very next cycle.
              wcnt_q    <= '0;
              g_q       <= '0;
              k_q       <= '0;
              xrd_q     <= '0;
              gbase_q   <= '0;
              s_ready_q <= 1'b0;
              state_q   <= COMPUTE;
            end else begin
              wcnt_q <= wcnt_q + AW'(1);
            end
          end
        end

        COMPUTE: begin
          if (k_q == M1) begin
            // Addresses hold at the last tap through DRAIN and OUTPUT.
            state_q  <= DRAIN;
            dcnt_q   <= '0;
            res_ld_q <= (DLAT == 0);
          end else begin
            k_q   <= k_q + WW'(1);
            xrd_q <= xrd_q + AW'(1);
          end
        end

        DRAIN: begin
          if (dcnt_q == DLAT_C) begin
            state_q   <= OUTPUT;
            m_valid_q <= 1'b1;
            lane_q    <= '0;
          end else begin
            dcnt_q   <= dcnt_q + DW'(1);
            res_ld_q <= ((dcnt_q + DW'(1)) == DLAT_C);
          end
        end

        OUTPUT: begin
          if (m_ready_y) begin
            if (lane_q == P1) begin
              lane_q    <= '0;
              m_valid_q <= 1'b0;
              if (g_q == G1) begin
                state_q   <= LOAD;
                s_ready_q <= 1'b1;
              end else begin
                g_q     <= g_q + GW'(1);
                k_q     <= '0;
                gbase_q <= gbase_q + P_AW;
                xrd_q   <= gbase_q + P_AW;
                state_q <= COMPUTE;
              end
            end else begin
              lane_q <= lane_q + SW'(1);
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0] perf_vec_q;
  logic [31:0] perf_stall_q;
  logic        vec_done;

  assign vec_done = (state_q == OUTPUT) && m_ready_y && (lane_q == P1) && (g_q == G1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_vec_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (vec_done && (perf_vec_q != '1)) perf_vec_q <= perf_vec_q + 32'd1;
      if (m_valid_q && !m_ready_y && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_vec_cnt   = perf_vec_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance: N=64 M=33 P=4 RD_LAT=1 MAC_LAT=2
  logic       reset = 1'b1;
  logic       s_valid_x = 1'b0;
  logic       m_ready_y = 1'b0;
  logic       s_ready_x, x_wr_en, mac_clr, mac_en, res_ld, m_valid_y;
  logic [5:0] x_wr_addr, x_rd_addr, w_rd_addr;
  logic [1:0] out_sel;

  // Small instance: N=8 M=5 P=4 RD_LAT=0 MAC_LAT=1
  logic       rst2 = 1'b1;
  logic       s_valid2 = 1'b0;
  logic       m_ready2 = 1'b0;
  logic       s_ready2, x_wr_en2, mac_clr2, mac_en2, res_ld2, m_valid2;
  logic [2:0] x_wr_addr2, x_rd_addr2, w_rd_addr2;
  logic [1:0] out_sel2;

`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0] perf_vec_cnt, perf_stall_cnt, perf_vec2, perf_stall2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  conv_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .x_wr_en   (x_wr_en),
    .x_wr_addr (x_wr_addr),
    .x_rd_addr (x_rd_addr),
    .w_rd_addr (w_rd_addr),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .res_ld    (res_ld),
    .out_sel   (out_sel),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y)
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    .perf_vec_cnt   (perf_vec_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  conv_seq_ctrl #(
    .N(8), .M(5), .P(4), .RD_LAT(0), .MAC_LAT(1)
  ) dut_small (
    .clk       (clk),
    .reset     (rst2),
    .s_valid_x (s_valid2),
    .s_ready_x (s_ready2),
    .x_wr_en   (x_wr_en2),
    .x_wr_addr (x_wr_addr2),
    .x_rd_addr (x_rd_addr2),
    .w_rd_addr (w_rd_addr2),
    .mac_clr   (mac_clr2),
    .mac_en    (mac_en2),
    .res_ld    (res_ld2),
    .out_sel   (out_sel2),
    .m_valid_y (m_valid2),
    .m_ready_y (m_ready2)
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    .perf_vec_cnt   (perf_vec2),
    .perf_stall_cnt (perf_stall2)
`endif
  );

  // Control bundle order: {mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en}

  task automatic test_reset();
    reset = 1'b1;
    s_valid_x = 1'b1;
    m_ready_y = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_ctl got %b want 000000",
               {mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en});
    end
    n_cmp++;
    if ({x_wr_addr, x_rd_addr, w_rd_addr, out_sel} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_addr got %h want 00000", {x_wr_addr, x_rd_addr, w_rd_addr, out_sel});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full vector with s_valid_x=1 and m_ready_y=1, starting in the cycle
  // right after reset is released. Compute entry is cycle 65; each group
  // takes 41 cycles (33 issue + 4 drain + 4 output).
  task automatic run_vector(input string tag);
    logic [5:0] exp;
    int rel, gi, r;
    for (int c = 0; c <= 65 + 328; c++) begin
      if (c > 0) @(negedge clk);
      s_valid_x = 1'b1;
      m_ready_y = 1'b1;
      #1;
      rel = c - 65;
      gi  = (rel >= 0) ? rel / 41 : 0;
      r   = (rel >= 0) ? rel % 41 : 0;
      if (c == 0)              exp = 6'b000000;
      else if (c <= 64)        exp = 6'b000011;
      else if (c < 65 + 328) begin
        exp = 6'b000000;
        exp[5] = (r >= 1) && (r <= 33);
        exp[4] = (r == 1);
        exp[3] = (r == 36);
        exp[2] = (r >= 37);
      end
      else                     exp = 6'b000011;
      n_cmp++;
      if ({mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en} !== exp) begin
        n_err++;
        $display("FAIL %s ctl c=%0d got %b want %b", tag, c,
                 {mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en}, exp);
      end
      if (c >= 1 && c <= 64) begin
        n_cmp++;
        if (x_wr_addr !== 6'(c - 1)) begin
          n_err++;
          $display("FAIL %s wr_addr c=%0d got %0d want %0d", tag, c, x_wr_addr, c - 1);
        end
      end
      if (c >= 65 && c < 65 + 328 && r <= 32) begin
        n_cmp++;
        if ({x_rd_addr, w_rd_addr} !== {6'(gi * 4 + r), 6'(r)}) begin
          n_err++;
          $display("FAIL %s rd_addr g=%0d k=%0d got x=%0d w=%0d want x=%0d w=%0d",
                   tag, gi, r, x_rd_addr, w_rd_addr, gi * 4 + r, r);
        end
      end
      if (c >= 65 && c < 65 + 328 && r >= 37) begin
        n_cmp++;
        if (out_sel !== 2'(r - 37)) begin
          n_err++;
          $display("FAIL %s out_sel g=%0d got %0d want %0d", tag, gi, out_sel, r - 37);
        end
      end
    end
    s_valid_x = 1'b0;
  endtask

  task automatic test_stall();
    int n = 0;
    int outs;
    bit found = 1'b0;
    bit back = 1'b0;
`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0] base;
`endif
    for (int i = 0; i < 300 && n < 64; i++) begin
      @(negedge clk);
      s_valid_x = 1'b1;
      m_ready_y = 1'b1;
      #1;
      if (x_wr_en) n++;
    end
    n_cmp++;
    if (n != 64) begin
      n_err++;
      $display("FAIL stall_load accepts got %0d want 64", n);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      s_valid_x = 1'b0;
      #1;
      if (m_valid_y) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found || out_sel !== 2'd0) begin
      n_err++;
      $display("FAIL stall_first_valid found=%0d out_sel=%0d want found=1 out_sel=0", found, out_sel);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({m_valid_y, out_sel} !== 3'b101) begin
      n_err++;
      $display("FAIL stall_lane1 got %b want 101", {m_valid_y, out_sel});
    end
    @(negedge clk);
    m_ready_y = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid_y, out_sel} !== 3'b110) begin
      n_err++;
      $display("FAIL stall_lane2 got %b want 110", {m_valid_y, out_sel});
    end
`ifdef CONV_SEQ_CTRL_PERF_EN
    base = perf_stall_cnt;
`endif
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({out_sel, m_valid_y, res_ld, mac_en, mac_clr, s_ready_x} !== 7'b1010000) begin
        n_err++;
        $display("FAIL stall_hold i=%0d got %b want 1010000", i,
                 {out_sel, m_valid_y, res_ld, mac_en, mac_clr, s_ready_x});
      end
    end
    @(negedge clk);
    m_ready_y = 1'b1;
    #1;
    n_cmp++;
    if ({m_valid_y, out_sel} !== 3'b110) begin
      n_err++;
      $display("FAIL stall_release got %b want 110", {m_valid_y, out_sel});
    end
`ifdef CONV_SEQ_CTRL_PERF_EN
    n_cmp++;
    if (perf_stall_cnt - base !== 32'd20) begin
      n_err++;
      $display("FAIL perf_stall delta got %0d want 20", perf_stall_cnt - base);
    end
`endif
    outs = 2;
    for (int i = 0; i < 600; i++) begin
      if (m_valid_y && m_ready_y) outs++;
      if (s_ready_x) begin back = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (!back || outs != 32) begin
      n_err++;
      $display("FAIL stall_vector back_to_load=%0d outputs got %0d want 32", back, outs);
    end
  endtask

  task automatic test_random();
    int acc = 0;
    int outs = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [1:0] prev_sel = '0;
    logic [5:0] prev_rd = '0;
    logic [5:0] prev_w = '0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_cmp++;
        if ({m_valid_y, out_sel, x_rd_addr, w_rd_addr} !== {1'b1, prev_sel, prev_rd, prev_w}) begin
          n_err++;
          $display("FAIL rand_hold cyc=%0d got v=%b sel=%0d x=%0d w=%0d want v=1 sel=%0d x=%0d w=%0d",
                   cyc, m_valid_y, out_sel, x_rd_addr, w_rd_addr, prev_sel, prev_rd, prev_w);
        end
      end
      s_valid_x = 1'($urandom_range(0, 1));
      m_ready_y = 1'($urandom_range(0, 1));
      #1;
      if (x_wr_en) begin
        n_cmp++;
        if (x_wr_addr !== 6'(acc % 64)) begin
          n_err++;
          $display("FAIL rand_wr_addr acc=%0d got %0d want %0d", acc, x_wr_addr, acc % 64);
        end
        acc++;
      end
      if (m_valid_y && m_ready_y) begin
        n_cmp++;
        if (out_sel !== 2'(outs % 4)) begin
          n_err++;
          $display("FAIL rand_out_sel out=%0d got %0d want %0d", outs, out_sel, outs % 4);
        end
        outs++;
      end
      prev_stall = m_valid_y && !m_ready_y;
      prev_sel   = out_sel;
      prev_rd    = x_rd_addr;
      prev_w     = w_rd_addr;
      if (outs == 1280) begin done = 1'b1; break; end
    end
    s_valid_x = 1'b0;
    n_cmp++;
    if (!done || acc != 2560 || outs != 1280) begin
      n_err++;
      $display("FAIL rand_counts done=%0d accepts got %0d want 2560 outputs got %0d want 1280",
               done, acc, outs);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    for (int i = 0; i < 300 && n < 64; i++) begin
      @(negedge clk);
      s_valid_x = 1'b1;
      m_ready_y = 1'b1;
      #1;
      if (x_wr_en) n++;
    end
    n_cmp++;
    if (n != 64) begin
      n_err++;
      $display("FAIL rmid_load accepts got %0d want 64", n);
    end
    // group 5, tap 10 is 5*41+10 cycles after compute entry
    for (int i = 0; i <= 215; i++) begin
      @(negedge clk);
      s_valid_x = 1'b0;
    end
    #1;
    n_cmp++;
    if ({x_rd_addr, w_rd_addr, mac_en} !== {6'd30, 6'd10, 1'b1}) begin
      n_err++;
      $display("FAIL rmid_pos got x=%0d w=%0d en=%b want x=30 w=10 en=1", x_rd_addr, w_rd_addr, mac_en);
    end
    s_valid_x = 1'b1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en} !== 6'b000000) begin
      n_err++;
      $display("FAIL rmid_ctl got %b want 000000",
               {mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en});
    end
    n_cmp++;
    if ({x_wr_addr, x_rd_addr, w_rd_addr, out_sel} !== 20'h0) begin
      n_err++;
      $display("FAIL rmid_addr got %h want 00000", {x_wr_addr, x_rd_addr, w_rd_addr, out_sel});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en} !== 6'b000000) begin
        n_err++;
        $display("FAIL rmid_hold i=%0d got %b want 000000", i,
                 {mac_en, mac_clr, res_ld, m_valid_y, s_ready_x, x_wr_en});
      end
    end
    @(negedge clk);
    reset = 1'b0;
    run_vector("post_reset");
  endtask

  // Small build: compute entry at cycle 9, mac_en concurrent with the
  // addresses, res_ld 6 cycles later, first valid 7 cycles after entry.
  task automatic test_small_params();
    logic [5:0] exp;
    int r;
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      s_valid2 = 1'b1;
      m_ready2 = 1'b1;
      #1;
      r = c - 9;
      if (c == 0)       exp = 6'b000000;
      else if (c <= 8)  exp = 6'b000011;
      else if (c < 20) begin
        exp = 6'b000000;
        exp[5] = (r <= 4);
        exp[4] = (r == 0);
        exp[3] = (r == 6);
        exp[2] = (r >= 7);
      end
      else              exp = 6'b000011;
      n_cmp++;
      if ({mac_en2, mac_clr2, res_ld2, m_valid2, s_ready2, x_wr_en2} !== exp) begin
        n_err++;
        $display("FAIL small_ctl c=%0d got %b want %b", c,
                 {mac_en2, mac_clr2, res_ld2, m_valid2, s_ready2, x_wr_en2}, exp);
      end
      if (c >= 1 && c <= 8) begin
        n_cmp++;
        if (x_wr_addr2 !== 3'(c - 1)) begin
          n_err++;
          $display("FAIL small_wr_addr c=%0d got %0d want %0d", c, x_wr_addr2, c - 1);
        end
      end
      if (c >= 9 && r <= 4) begin
        n_cmp++;
        if ({x_rd_addr2, w_rd_addr2} !== {3'(r), 3'(r)}) begin
          n_err++;
          $display("FAIL small_rd_addr k=%0d got x=%0d w=%0d want %0d", r, x_rd_addr2, w_rd_addr2, r);
        end
      end
      if (c >= 16 && c < 20) begin
        n_cmp++;
        if (out_sel2 !== 2'(r - 7)) begin
          n_err++;
          $display("FAIL small_out_sel got %0d want %0d", out_sel2, r - 7);
        end
      end
    end
    s_valid2 = 1'b0;
  endtask

  initial begin
    test_reset();
    run_vector("vec0");
    test_stall();
    test_random();
    test_reset_mid();
    test_small_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
